// File: rtl/rx_desc_control.sv
// RX descriptor controller: arms the DMA with free descriptors, polls their status word and retires completed ones.
// Optional packet counter output rx_pkt_count is built when RX_DESC_STATS_EN is defined.
module rx_desc_control #(
  parameter int          ADDR_WIDTH       = 32,
  parameter int          DATA_WIDTH       = 32,
  parameter logic [31:0] RX_STATUS_OFFSET = 32'h0014,
  parameter int          RX_DONE_BIT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_poll,
  output logic [2:0]            ipic_type_lite,
  output logic                  ipic_start_lite,
  input  logic                  ipic_done_lite_wire,
  output logic [ADDR_WIDTH-1:0] read_addr_lite,
  input  logic [DATA_WIDTH-1:0] single_read_data_lite,
  output logic [ADDR_WIDTH-1:0] write_addr_lite,
  output logic [DATA_WIDTH-1:0] write_data_lite,
  input  logic [DATA_WIDTH-1:0] rxfifo_dread,
  output logic                  rxfifo_rd_en,
  input  logic                  rxfifo_empty,
  input  logic                  rxfifo_valid,
  output logic                  rxdone_wr_start,
  output logic [DATA_WIDTH-1:0] rxdone_wr_data,
  input  logic                  rxdone_wr_done
`ifdef RX_DESC_STATS_EN
  , output logic [15:0]         rx_pkt_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] AR_RXDP = ADDR_WIDTH'(32'h000C);

  typedef enum logic [2:0] {LOAD, ARM, IDLE, RD_STAT, CHECK, PUSH, PUSH_WAIT} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] cur_desc, cur_desc_n;
  logic                  poll_q, poll_rise, poll_pending, poll_pending_n;
  logic                  stat_done, stat_done_n;
  logic                  start_n, rd_en_n, wr_start_n;
  logic [2:0]            type_n;
  logic [ADDR_WIDTH-1:0] raddr_n, waddr_n;
  logic [DATA_WIDTH-1:0] wdata_n, wr_data_n;
  logic                  unused_rd_bits;

  // Only the done flag of the status word matters here.
  assign unused_rd_bits = ^single_read_data_lite;

  function automatic logic [ADDR_WIDTH-1:0] status_addr(input logic [DATA_WIDTH-1:0] desc);
    status_addr = ADDR_WIDTH'(desc) + ADDR_WIDTH'(RX_STATUS_OFFSET);
  endfunction

  assign poll_rise = rx_poll & ~poll_q;

  always_comb begin
    state_n        = state;
    cur_desc_n     = cur_desc;
    stat_done_n    = stat_done;
    poll_pending_n = poll_pending | poll_rise;
    start_n        = ipic_start_lite;
    type_n         = ipic_type_lite;
    raddr_n        = read_addr_lite;
    waddr_n        = write_addr_lite;
    wdata_n        = write_data_lite;
    wr_data_n      = rxdone_wr_data;
    rd_en_n        = 1'b0;
    wr_start_n     = 1'b0;
    case (state)
      LOAD: begin
        if (rxfifo_valid && !rxfifo_empty) begin
          rd_en_n    = 1'b1;
          cur_desc_n = rxfifo_dread;
          start_n    = 1'b1;
          type_n     = 3'd3;
          waddr_n    = AR_RXDP;
          wdata_n    = rxfifo_dread;
          state_n    = ARM;
        end
      end
      ARM: begin
        if (ipic_done_lite_wire) begin
          start_n = 1'b0;
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (poll_pending) begin
          // A fresh edge landing on the clearing cycle must survive.
          poll_pending_n = poll_rise;
          start_n        = 1'b1;
          type_n         = 3'd2;
          raddr_n        = status_addr(cur_desc);
          state_n        = RD_STAT;
        end
      end
      RD_STAT: begin
        if (ipic_done_lite_wire) begin
          stat_done_n = single_read_data_lite[RX_DONE_BIT];
          start_n     = 1'b0;
          state_n     = CHECK;
        end
      end
      CHECK: begin
        if (stat_done) begin
          wr_start_n = 1'b1;
          wr_data_n  = cur_desc;
          state_n    = PUSH;
        end else begin
          state_n = IDLE;
        end
      end
      PUSH: state_n = PUSH_WAIT;
      PUSH_WAIT: begin
        if (rxdone_wr_done) begin
          poll_pending_n = 1'b1;
          state_n        = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= LOAD;
      cur_desc        <= '0;
      poll_q          <= 1'b0;
      poll_pending    <= 1'b0;
      ipic_start_lite <= 1'b0;
      ipic_type_lite  <= '0;
      read_addr_lite  <= '0;
      write_addr_lite <= '0;
      write_data_lite <= '0;
      rxfifo_rd_en    <= 1'b0;
      rxdone_wr_start <= 1'b0;
      rxdone_wr_data  <= '0;
    end else begin
      state           <= state_n;
      cur_desc        <= cur_desc_n;
      poll_q          <= rx_poll;
      poll_pending    <= poll_pending_n;
      ipic_start_lite <= start_n;
      ipic_type_lite  <= type_n;
      read_addr_lite  <= raddr_n;
      write_addr_lite <= waddr_n;
      write_data_lite <= wdata_n;
      rxfifo_rd_en    <= rd_en_n;
      rxdone_wr_start <= wr_start_n;
      rxdone_wr_data  <= wr_data_n;
    end
  end

  always_ff @(posedge clk) begin
    stat_done <= stat_done_n;
  end

`ifdef RX_DESC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_pkt_count <= '0;
    end else if (state == PUSH_WAIT && rxdone_wr_done) begin
      rx_pkt_count <= rx_pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_desc_control.sv
// Directed bench for rx_desc_control: descriptor load, RXDP arming, status polling, retire, FIFO stall and reset abort.
module tb_rx_desc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_poll;
  logic [2:0]  ipic_type_lite;
  logic        ipic_start_lite;
  logic        ipic_done_lite_wire;
  logic [31:0] read_addr_lite;
  logic [31:0] single_read_data_lite;
  logic [31:0] write_addr_lite;
  logic [31:0] write_data_lite;
  logic [31:0] rxfifo_dread;
  logic        rxfifo_rd_en;
  logic        rxfifo_empty;
  logic        rxfifo_valid;
  logic        rxdone_wr_start;
  logic [31:0] rxdone_wr_data;
  logic        rxdone_wr_done;
`ifdef RX_DESC_STATS_EN
  logic [15:0] rx_pkt_count;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_desc_control dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx_poll               (rx_poll),
    .ipic_type_lite        (ipic_type_lite),
    .ipic_start_lite       (ipic_start_lite),
    .ipic_done_lite_wire   (ipic_done_lite_wire),
    .read_addr_lite        (read_addr_lite),
    .single_read_data_lite (single_read_data_lite),
    .write_addr_lite       (write_addr_lite),
    .write_data_lite       (write_data_lite),
    .rxfifo_dread          (rxfifo_dread),
    .rxfifo_rd_en          (rxfifo_rd_en),
    .rxfifo_empty          (rxfifo_empty),
    .rxfifo_valid          (rxfifo_valid),
    .rxdone_wr_start       (rxdone_wr_start),
    .rxdone_wr_data        (rxdone_wr_data),
    .rxdone_wr_done        (rxdone_wr_done)
`ifdef RX_DESC_STATS_EN
    , .rx_pkt_count        (rx_pkt_count)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rx_poll = 1'b0; ipic_done_lite_wire = 1'b0;
    single_read_data_lite = '0; rxdone_wr_done = 1'b0;
    rxfifo_dread = 32'h1000; rxfifo_valid = 1'b1; rxfifo_empty = 1'b0;
    tick(); tick();
    check_val("rst_start", ipic_start_lite, 0);
    check_val("rst_rd_en", rxfifo_rd_en, 0);
    check_val("rst_wr_start", rxdone_wr_start, 0);
    check_val("rst_type", ipic_type_lite, 0);
    check_val("rst_cur_desc", dut.cur_desc, 0);

    // Load 0x1000 and arm RXDP
    reset = 1'b0;
    tick();
    check_val("load_rd_en", rxfifo_rd_en, 1);
    check_val("arm_start", ipic_start_lite, 1);
    check_val("arm_type", ipic_type_lite, 3);
    check_val("arm_waddr", write_addr_lite, 32'h000C);
    check_val("arm_wdata", write_data_lite, 32'h1000);
    rxfifo_dread = 32'h2000;
    tick();
    check_val("rd_en_one_cycle", rxfifo_rd_en, 0);
    check_val("arm_hold_start", ipic_start_lite, 1);
    ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    check_val("arm_done_start", ipic_start_lite, 0);
    tick();
    check_val("idle_no_start", ipic_start_lite, 0);
    check_val("idle_cur_desc", dut.cur_desc, 32'h1000);

    // Poll, status not done
    rx_poll = 1'b1; tick(); rx_poll = 1'b0; tick();
    check_val("rd1_start", ipic_start_lite, 1);
    check_val("rd1_type", ipic_type_lite, 2);
    check_val("rd1_addr", read_addr_lite, 32'h1014);
    single_read_data_lite = 32'h0; ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    check_val("rd1_done_start", ipic_start_lite, 0);
    tick(); tick();
    check_val("nodone_wr_start", rxdone_wr_start, 0);
    check_val("nodone_start", ipic_start_lite, 0);
    check_val("nodone_cur_desc", dut.cur_desc, 32'h1000);

    // Poll, status done: retire 0x1000, auto-load 0x2000
    rx_poll = 1'b1; tick(); rx_poll = 1'b0; tick();
    check_val("rd2_addr", read_addr_lite, 32'h1014);
    single_read_data_lite = 32'h1; ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    tick();
    check_val("push_wr_start", rxdone_wr_start, 1);
    check_val("push_wr_data", rxdone_wr_data, 32'h1000);
    tick();
    check_val("push_one_cycle", rxdone_wr_start, 0);
    rxdone_wr_done = 1'b1;
    tick();
    rxdone_wr_done = 1'b0;
    check_val("load2_no_start", ipic_start_lite, 0);
    tick();
    check_val("load2_rd_en", rxfifo_rd_en, 1);
    check_val("arm2_type", ipic_type_lite, 3);
    check_val("arm2_waddr", write_addr_lite, 32'h000C);
    check_val("arm2_wdata", write_data_lite, 32'h2000);
    rxfifo_valid = 1'b0; rxfifo_empty = 1'b1;
    ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    check_val("arm2_done_start", ipic_start_lite, 0);
    tick();
    check_val("auto_rd_start", ipic_start_lite, 1);
    check_val("auto_rd_type", ipic_type_lite, 2);
    check_val("auto_rd_addr", read_addr_lite, 32'h2014);
    single_read_data_lite = 32'h1; ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    tick();
    check_val("push2_wr_data", rxdone_wr_data, 32'h2000);
    tick();
    rxdone_wr_done = 1'b1;
    tick();
    rxdone_wr_done = 1'b0;

    // FIFO empty: stall in LOAD, absorb a poll, resume on 0x3000
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("stall_start", ipic_start_lite, 0);
      check_val("stall_rd_en", rxfifo_rd_en, 0);
    end
    rx_poll = 1'b1; tick(); rx_poll = 1'b0; tick();
    check_val("stall_pending", dut.poll_pending, 1);
    rxfifo_dread = 32'h3000; rxfifo_valid = 1'b1; rxfifo_empty = 1'b0;
    tick();
    check_val("resume_rd_en", rxfifo_rd_en, 1);
    check_val("resume_waddr", write_addr_lite, 32'h000C);
    check_val("resume_wdata", write_data_lite, 32'h3000);
    rxfifo_valid = 1'b0; rxfifo_empty = 1'b1;
    ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    rx_poll = 1'b1;
    tick();
    check_val("resume_rd_start", ipic_start_lite, 1);
    check_val("resume_rd_addr", read_addr_lite, 32'h3014);
    check_val("edge_on_clear_pending", dut.poll_pending, 1);

    // Reset in RD_STAT, late done ignored
    reset = 1'b1; rx_poll = 1'b0;
    tick();
    check_val("abort_start", ipic_start_lite, 0);
    check_val("abort_type", ipic_type_lite, 0);
    check_val("abort_raddr", read_addr_lite, 0);
    check_val("abort_waddr", write_addr_lite, 0);
    check_val("abort_wdata", write_data_lite, 0);
    check_val("abort_wr_data", rxdone_wr_data, 0);
    check_val("abort_pending", dut.poll_pending, 0);
    check_val("abort_cur_desc", dut.cur_desc, 0);
    reset = 1'b0; ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    check_val("late_done_start", ipic_start_lite, 0);
    check_val("late_done_rd_en", rxfifo_rd_en, 0);
    check_val("late_done_wr_start", rxdone_wr_start, 0);
    rxfifo_dread = 32'h4000; rxfifo_valid = 1'b1; rxfifo_empty = 1'b0;
    tick();
    check_val("post_rst_rd_en", rxfifo_rd_en, 1);
    check_val("post_rst_wdata", write_data_lite, 32'h4000);
    rxfifo_valid = 1'b0; rxfifo_empty = 1'b1;
    ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;

`ifdef RX_DESC_STATS_EN
    check_val("cnt_after_reset", rx_pkt_count, 0);
    force dut.rx_pkt_count = 16'hFFFF;
    tick();
    release dut.rx_pkt_count;
    rx_poll = 1'b1; tick(); rx_poll = 1'b0; tick();
    single_read_data_lite = 32'h1; ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    tick(); tick();
    check_val("cnt_preload", rx_pkt_count, 16'hFFFF);
    rxdone_wr_done = 1'b1;
    tick();
    rxdone_wr_done = 1'b0;
    check_val("cnt_wrap", rx_pkt_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
